gpr_wb_ctrl: RTL and testbench
==============================

GPR_WB_CTRL -- requirements
Module: gpr_wb_ctrl

Interface
REQ-001 SHALL provide: DEPTH, 4, number of pending-writeback FIFO entries, power of two, 2..16.
REQ-002 SHALL provide: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL provide: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide: a_valid  in  1  pipeline writeback request, always accepted.
REQ-005 SHALL provide: a_addr  in  5 / a_data  in  32  pipeline destination register and result.
REQ-006 SHALL provide: b_valid  in  1 / b_ready  out  1  multi-cycle-unit request handshake.
REQ-007 SHALL provide: b_addr  in  5 / b_data  in  32  multi-cycle-unit destination and result.
REQ-008 SHALL provide: wr  out  1 / waddr  out  5 / wd  out  32  register-file write port drive.
REQ-009 SHALL provide: raddr0, raddr1  in  5  read addresses being issued to the register file.
REQ-010 SHALL provide: fwd_hit0, fwd_hit1  out  1 / fwd_data0, fwd_data1  out  32  bypass results.
REQ-011 SHALL provide: pending  out  log2(DEPTH)+1  count of FIFO entries, including squashed.

Function
REQ-012 SHALL register wr/waddr/wd: request accepted in cycle N appears on write port in cycle N+1.
REQ-013 SHALL drop any request with address 0 (no enqueue, no write, no stall).
REQ-014 SHALL give source A absolute priority: a_valid with a_addr!=0 loads the write-port register.
REQ-015 SHALL enqueue B on b_valid && b_ready; b_ready = (pending < DEPTH), independent of b_valid.
REQ-016 SHALL write FIFO head to the port when no A write is loaded that cycle and head is unsquashed; head then pops.
REQ-017 SHALL pop a squashed head in one cycle with no port write, regardless of A.
REQ-018 SHALL squash every pending FIFO entry whose address equals a_addr when A writes (A is younger).
REQ-019 SHALL NOT squash a B request enqueued in the same cycle as an A write to the same address.
REQ-020 SHALL allow enqueue and pop in the same cycle; pending then unchanged.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; full = pending==DEPTH, empty = pending==0.
REQ-022 SHALL deassert wr in any cycle where nothing was loaded; waddr/wd then hold previous value.
REQ-023 SHALL compute bypass combinationally per read port: youngest unsquashed FIFO match first, else write-port register if wr and waddr match, else no hit.
REQ-024 SHALL never hit for raddr 0; fwd_data is 0 when fwd_hit is 0.

Reset
REQ-025 SHALL on rst_n low immediately clear wr, waddr, wd, pointers, pending, squash flags; b_ready 1 after release.
REQ-026 SHALL discard in-flight FIFO contents on reset mid-operation; no write issued after release until a new request.

Configuration
REQ-027 SHALL compile bypass logic only when GPR_WB_FWD_EN is defined.
REQ-028 SHALL without GPR_WB_FWD_EN tie fwd_hit0/1 and fwd_data0/1 to 0; all other behaviour identical.

Structure
REQ-029 SHALL place DEPTH default, register-address width (5), data width (32) in shared package mips_pkg.
REQ-030 SHALL implement the FIFO with squash flags as sub-module wb_fifo; arbitration, port register and bypass in top.

Verification
REQ-031 SHALL cover: a_valid, a_addr=3, a_data=0x11 -> next cycle wr=1, waddr=3, wd=0x11.
REQ-032 SHALL cover: 4 B requests (addr 1..4) while a_valid held 1 to addr 9 -> b_ready=0, pending=4; release A -> writes 1,2,3,4 on consecutive cycles.
REQ-033 SHALL cover: B addr 5 data 0xAA pending, A writes addr 5 data 0xBB -> port writes 0xBB, squashed entry pops with wr=0, final value 0xBB.
REQ-034 SHALL cover: B addr 7 data 0x1 then 0x2 pending, raddr0=7 -> fwd_hit0=1, fwd_data0=0x2 (0 without GPR_WB_FWD_EN).
REQ-035 SHALL cover: a_valid with a_addr=0 and b_valid with b_addr=0 -> no enqueue, wr=0, pending unchanged.
REQ-036 SHALL cover: rst_n low with pending=3 -> wr=0, pending=0, b_ready=1, no write after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and sizes for the GPR writeback controller.
// Holds the default FIFO depth, register address/data widths and request structs.
// Used by the interface, the writeback FIFO and the controller top.
package mips_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int REG_AW    = 5;
  localparam int DATA_W    = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // One pending register-file write.
  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  // Result of a bypass lookup for one read port.
  typedef struct packed {
    logic      hit;
    reg_data_t data;
  } fwd_t;

  // Register 0 is hardwired; writes and lookups to it are ignored.
  function automatic logic addr_live(reg_addr_t a);
    return a != '0;
  endfunction

endpackage

// File: rtl/gpr_wb_ctrl_if.sv
// Bundle of request, write-port, bypass and status signals around gpr_wb_ctrl.
// master = pipeline/multi-cycle-unit side, slave = the controller.
// DEPTH must match the controller instance so that pending has the right width.
interface gpr_wb_ctrl_if
  import mips_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  // Pipeline writeback (never stalled)
  logic      a_valid;
  reg_addr_t a_addr;
  reg_data_t a_data;

  // Multi-cycle unit writeback (valid/ready)
  logic      b_valid;
  logic      b_ready;
  reg_addr_t b_addr;
  reg_data_t b_data;

  // Register-file write port
  logic      wr;
  reg_addr_t waddr;
  reg_data_t wd;

  // Bypass
  reg_addr_t raddr0;
  reg_addr_t raddr1;
  logic      fwd_hit0;
  logic      fwd_hit1;
  reg_data_t fwd_data0;
  reg_data_t fwd_data1;

  // FIFO occupancy, squashed entries included
  logic [CW-1:0] pending;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output raddr0, raddr1,
    input  b_ready, wr, waddr, wd,
    input  fwd_hit0, fwd_hit1, fwd_data0, fwd_data1,
    input  pending
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  raddr0, raddr1,
    output b_ready, wr, waddr, wd,
    output fwd_hit0, fwd_hit1, fwd_data0, fwd_data1,
    output pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Pending-writeback FIFO with per-entry squash flags and an age-ordered view for bypass.
// Latency: push visible at head/count one cycle later; pop and squash take effect on the next edge.
// Backpressure: none internally; caller must not push when full_o or pop when empty_o.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  wb_req_t                   push_dat_i,
  input  logic                      pop_i,
  input  logic                      sq_vld_i,
  input  reg_addr_t                 sq_addr_i,
  output wb_req_t                   head_o,
  output logic                      head_sq_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output wb_req_t [DEPTH-1:0]       ord_dat_o,
  output logic [DEPTH-1:0]          ord_live_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]    sq_q, sq_d;
  logic [PW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]       cnt_q;

  // Squash every stored entry matching the younger A write; a slot being filled
  // this cycle always starts unsquashed, so a same-cycle B survives.
  always_comb begin
    sq_d = sq_q;
    if (sq_vld_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].addr == sq_addr_i) sq_d[i] = 1'b1;
      end
    end
    if (push_i) sq_d[wr_ptr_q] = 1'b0;
  end

  // Pointers, occupancy and squash flags; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      sq_q     <= '0;
    end else begin
      sq_q <= sq_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage; contents are only meaningful below cnt_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Oldest-first view: index 0 is the head, higher indices are younger.
  always_comb begin
    ord_dat_o  = '0;
    ord_live_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ord_dat_o[i]  = mem_q[rd_ptr_q + PW'(i)];
      ord_live_o[i] = (CW'(i) < cnt_q) && !sq_q[rd_ptr_q + PW'(i)];
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign head_sq_o = sq_q[rd_ptr_q];
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign count_o   = cnt_q;

endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR writeback arbiter: pipeline (A) beats the FIFO'd multi-cycle unit (B) onto one write port.
// Latency: accepted request drives wr/waddr/wd the next cycle; bypass outputs are combinational.
// Backpressure: A never stalls; b_ready drops only while the FIFO is full. Bypass built with GPR_WB_FWD_EN.
module gpr_wb_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  gpr_wb_ctrl_if.slave  bus
);

  logic                   a_wr, b_push, pop, head_wr;
  logic                   head_sq, empty, full;
  wb_req_t                push_dat, head;
  logic [$clog2(DEPTH):0] cnt;
  wb_req_t [DEPTH-1:0]    ord_dat;
  logic [DEPTH-1:0]       ord_live;

  logic      wr_q, wr_d;
  reg_addr_t waddr_q, waddr_d;
  reg_data_t wd_q, wd_d;

  assign a_wr     = bus.a_valid && addr_live(bus.a_addr);
  assign b_push   = bus.b_valid && !full && addr_live(bus.b_addr);
  assign push_dat = '{addr: bus.b_addr, data: bus.b_data};

  // A squashed head is dead weight and leaves immediately; a live head waits for a free port.
  assign pop      = !empty && (head_sq || !a_wr);
  assign head_wr  = pop && !head_sq;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (b_push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .sq_vld_i   (a_wr),
    .sq_addr_i  (bus.a_addr),
    .head_o     (head),
    .head_sq_o  (head_sq),
    .empty_o    (empty),
    .full_o     (full),
    .count_o    (cnt),
    .ord_dat_o  (ord_dat),
    .ord_live_o (ord_live)
  );

  // Choose what lands on the write port next cycle; address/data hold when idle.
  always_comb begin
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wd_d    = wd_q;
    if (a_wr) begin
      wr_d    = 1'b1;
      waddr_d = bus.a_addr;
      wd_d    = bus.a_data;
    end else if (head_wr) begin
      wr_d    = 1'b1;
      waddr_d = head.addr;
      wd_d    = head.data;
    end
  end

  // Write-port register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wd_q    <= '0;
    end else begin
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.wr      = wr_q;
  assign bus.waddr   = waddr_q;
  assign bus.wd      = wd_q;
  assign bus.b_ready = !full;
  assign bus.pending = cnt;

`ifdef GPR_WB_FWD_EN
  // Youngest live FIFO entry wins, then the write-port register, else miss.
  function automatic fwd_t fwd_lookup(
    input reg_addr_t           ra,
    input wb_req_t [DEPTH-1:0] dat,
    input logic [DEPTH-1:0]    live,
    input logic                pwr,
    input reg_addr_t           pa,
    input reg_data_t           pd
  );
    fwd_t r;
    r = '0;
    if (addr_live(ra)) begin
      if (pwr && pa == ra) begin
        r.hit  = 1'b1;
        r.data = pd;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (live[i] && dat[i].addr == ra) begin
          r.hit  = 1'b1;
          r.data = dat[i].data;
        end
      end
    end
    return r;
  endfunction

  fwd_t f0, f1;

  // Per-read-port bypass lookup.
  always_comb begin
    f0 = fwd_lookup(bus.raddr0, ord_dat, ord_live, wr_q, waddr_q, wd_q);
    f1 = fwd_lookup(bus.raddr1, ord_dat, ord_live, wr_q, waddr_q, wd_q);
  end

  assign bus.fwd_hit0  = f0.hit;
  assign bus.fwd_data0 = f0.data;
  assign bus.fwd_hit1  = f1.hit;
  assign bus.fwd_data1 = f1.data;
`else
  logic unused_fwd;
  assign unused_fwd    = ^{ord_dat, ord_live, bus.raddr0, bus.raddr1};
  assign bus.fwd_hit0  = 1'b0;
  assign bus.fwd_data0 = '0;
  assign bus.fwd_hit1  = 1'b0;
  assign bus.fwd_data1 = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed bench for gpr_wb_ctrl: priority, FIFO ordering, squash, bypass and reset.
// Inputs change 1ns after a rising edge; outputs are checked there too.
// Bypass expectations follow GPR_WB_FWD_EN.
module tb_gpr_wb_ctrl;
  import mips_pkg::*;

  localparam int DEPTH = 4;
`ifdef GPR_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  gpr_wb_ctrl_if #(.DEPTH(DEPTH)) bus ();

  gpr_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
    bus.a_valid = v; bus.a_addr = ad; bus.a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] ad, input logic [31:0] d);
    bus.b_valid = v; bus.b_addr = ad; bus.b_data = d;
  endtask

  task automatic port(input string tag, input logic w, input logic [4:0] ad, input logic [31:0] d);
    check({tag, ".wr"},    32'(bus.wr),    32'(w));
    check({tag, ".waddr"}, 32'(bus.waddr), 32'(ad));
    check({tag, ".wd"},    bus.wd,         d);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.raddr0 = '0;
    bus.raddr1 = '0;

    // Reset state
    #3;
    port("rst", 1'b0, 5'd0, 32'h0);
    check("rst.pending", 32'(bus.pending), 0);
    check("rst.b_ready", 32'(bus.b_ready), 1);
    check("rst.fwd_hit0", 32'(bus.fwd_hit0), 0);
    #9 rst_n = 1'b1;
    tick();

    // A write lands next cycle, then port idles holding address/data
    drive_a(1'b1, 5'd3, 32'h11);
    tick();
    port("a3", 1'b1, 5'd3, 32'h11);
    idle();
    tick();
    port("a3.idle", 1'b0, 5'd3, 32'h11);

    // Address 0 requests are dropped on both sources
    drive_a(1'b1, 5'd0, 32'h55);
    drive_b(1'b1, 5'd0, 32'h66);
    tick();
    port("zero", 1'b0, 5'd3, 32'h11);
    check("zero.pending", 32'(bus.pending), 0);
    check("zero.b_ready", 32'(bus.b_ready), 1);
    idle();

    // Fill FIFO behind a continuous A stream, then drain in order
    drive_a(1'b1, 5'd9, 32'h99);
    for (int k = 1; k <= 4; k++) begin
      drive_b(1'b1, 5'(k), 32'h100 + 32'(k));
      tick();
    end
    check("fill.pending", 32'(bus.pending), 4);
    check("fill.b_ready", 32'(bus.b_ready), 0);
    port("fill.a9", 1'b1, 5'd9, 32'h99);
    drive_b(1'b1, 5'd6, 32'h106);
    tick();
    check("full.pending", 32'(bus.pending), 4);
    idle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      port($sformatf("drain%0d", k), 1'b1, 5'(k), 32'h100 + 32'(k));
      check($sformatf("drain%0d.pending", k), 32'(bus.pending), 32'(4 - k));
    end
    tick();
    check("drain.done.wr", 32'(bus.wr), 0);
    check("drain.b_ready", 32'(bus.b_ready), 1);

    // Younger A write squashes the queued B to the same register
    drive_a(1'b1, 5'd9, 32'h9A);
    drive_b(1'b1, 5'd5, 32'hAA);
    tick();
    check("sq.pending1", 32'(bus.pending), 1);
    drive_a(1'b1, 5'd5, 32'hBB);
    drive_b(1'b0, 5'd0, 32'h0);
    tick();
    port("sq.a5", 1'b1, 5'd5, 32'hBB);
    check("sq.pending2", 32'(bus.pending), 1);
    idle();
    tick();
    port("sq.pop", 1'b0, 5'd5, 32'hBB);
    check("sq.pending3", 32'(bus.pending), 0);

    // Squashed head leaves even while A keeps the port busy
    drive_a(1'b1, 5'd9, 32'h9B);
    drive_b(1'b1, 5'd8, 32'h88);
    tick();
    drive_a(1'b1, 5'd8, 32'hC8);
    drive_b(1'b0, 5'd0, 32'h0);
    tick();
    check("sqa.pending1", 32'(bus.pending), 1);
    drive_a(1'b1, 5'd10, 32'hCA);
    tick();
    port("sqa.a10", 1'b1, 5'd10, 32'hCA);
    check("sqa.pending2", 32'(bus.pending), 0);
    idle();
    tick();

    // Same-cycle A and B to one register: B survives; then push+pop together
    drive_a(1'b1, 5'd12, 32'hA12);
    drive_b(1'b1, 5'd12, 32'hB12);
    tick();
    port("same.a", 1'b1, 5'd12, 32'hA12);
    check("same.pending1", 32'(bus.pending), 1);
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b1, 5'd13, 32'hD13);
    tick();
    port("same.b", 1'b1, 5'd12, 32'hB12);
    check("pushpop.pending", 32'(bus.pending), 1);
    idle();
    tick();
    port("pushpop.b13", 1'b1, 5'd13, 32'hD13);
    check("pushpop.pending0", 32'(bus.pending), 0);
    tick();

    // Bypass: youngest FIFO match, write-port match, and register 0
    drive_a(1'b1, 5'd9, 32'h909);
    drive_b(1'b1, 5'd7, 32'h1);
    tick();
    drive_b(1'b1, 5'd7, 32'h2);
    tick();
    drive_b(1'b0, 5'd0, 32'h0);
    bus.raddr0 = 5'd7;
    bus.raddr1 = 5'd9;
    #1;
    check("fwd.hit0", 32'(bus.fwd_hit0), 32'(FWD));
    check("fwd.data0", bus.fwd_data0, FWD ? 32'h2 : 32'h0);
    check("fwd.hit1", 32'(bus.fwd_hit1), 32'(FWD));
    check("fwd.data1", bus.fwd_data1, FWD ? 32'h909 : 32'h0);
    bus.raddr0 = 5'd0;
    bus.raddr1 = 5'd3;
    #1;
    check("fwd.r0.hit", 32'(bus.fwd_hit0), 0);
    check("fwd.r0.data", bus.fwd_data0, 32'h0);
    check("fwd.miss.hit", 32'(bus.fwd_hit1), 0);
    drive_a(1'b1, 5'd7, 32'h777);
    tick();
    bus.raddr0 = 5'd7;
    #1;
    check("fwd.sq.hit0", 32'(bus.fwd_hit0), 32'(FWD));
    check("fwd.sq.data0", bus.fwd_data0, FWD ? 32'h777 : 32'h0);
    idle();
    tick();
    check("fwd.pop.pending", 32'(bus.pending), 1);
    check("fwd.pop.hit0", 32'(bus.fwd_hit0), 0);
    tick();
    port("fwd.pop2", 1'b0, 5'd7, 32'h777);
    check("fwd.pop2.pending", 32'(bus.pending), 0);
    bus.raddr0 = '0;
    bus.raddr1 = '0;

    // Reset mid-operation discards queued writes
    drive_a(1'b1, 5'd9, 32'h919);
    for (int k = 1; k <= 3; k++) begin
      drive_b(1'b1, 5'(k), 32'h200 + 32'(k));
      tick();
    end
    check("mid.pending", 32'(bus.pending), 3);
    rst_n = 1'b0;
    #2;
    port("mid.rst", 1'b0, 5'd0, 32'h0);
    check("mid.rst.pending", 32'(bus.pending), 0);
    check("mid.rst.b_ready", 32'(bus.b_ready), 1);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    check("post.wr1", 32'(bus.wr), 0);
    tick();
    check("post.wr2", 32'(bus.wr), 0);
    check("post.pending", 32'(bus.pending), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
